prueba_tx: RTL and testbench

PRUEBA_TX -- requirements
Module: prueba_tx

---
 rtl/prueba_tx_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 102 ++++++++++
 rtl/prueba_tx.sv | 98 +++++++++
 tb/tb_prueba_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prueba_tx_pkg.sv
// Shared definitions for the prueba_tx UART word transmitter: FSM encoding,
// default bit timing and the bytes-per-word derivation.
package prueba_tx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      NEXT  = 3'd4
   } tx_state_e;

   // 50 MHz system clock at 9600 baud
   localparam int CLKS_PER_BIT_DEF = 5208;

   function automatic int nb_of(input int word_bits);
      return (word_bits + 7) / 8;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer with its own bit timer. The stop bit is split into STOP
// (CLKS_PER_BIT-1 cycles) and NEXT (1 cycle) so a following byte can start with no gap.
module uart_tx_byte
   import prueba_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF  // must be >= 2
) (
   input  logic       Clk_G,
   input  logic       Rst_G,
   input  logic       byte_start_i,
   input  logic [7:0] byte_data_i,
   output logic       tx_o,
   output logic       byte_busy_o,
   output logic       byte_done_o,
   output tx_state_e  state_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

   // Handshake: byte_start_i is taken only in IDLE or NEXT; byte_done_o is high
   // for the single NEXT cycle, when the caller may chain the next byte.
   tx_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            bit_end;

   assign bit_end = (cnt_q == BIT_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (byte_start_i) begin
               state_d = START;
               cnt_d   = '0;
               bit_d   = '0;
               shift_d = byte_data_i;
            end
         end
         START: if (bit_end) state_d = DATA;
         DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end
         end
         STOP: if (cnt_q == STOP_LAST) state_d = NEXT;
         NEXT: begin
            if (byte_start_i) begin
               state_d = START;
               bit_d   = '0;
               shift_d = byte_data_i;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Line level is registered from the next state so Tx never glitches
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge Clk_G or posedge Rst_G) begin
      if (Rst_G) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx_o        = tx_q;
   assign byte_busy_o = (state_q != IDLE);
   assign byte_done_o = (state_q == NEXT);
   assign state_o     = state_q;

endmodule

// File: rtl/prueba_tx.sv
// Sends a signed controller word over UART as sign-extended bytes, LSB first,
// back-to-back, with word-level busy/done status.
module prueba_tx
   import prueba_tx_pkg::*;
#(
   parameter int cant_bits    = 13,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic                        Clk_G,
   input  logic                        Rst_G,
   input  logic                        Tx_Start,
   input  logic signed [2*cant_bits-1:0] Dato,
   output logic                        Tx,
   output logic                        Tx_Busy,
   output logic                        Tx_Done
);

   localparam int W  = 2 * cant_bits;
   localparam int NB = nb_of(W);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   logic signed [W-1:0]    dato_q, dato_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic signed [8*NB-1:0] ext_w;
   logic [7:0]             word_bytes [NB];
   logic                   byte_start, byte_busy, byte_done;
   logic [7:0]             byte_data;
   tx_state_e              byte_state;
   logic                   accept, last_byte;

   // Signed size cast replicates the word's top bit into the padding bytes
   assign ext_w = (8*NB)'(dato_q);

   always_comb begin
      for (int i = 0; i < NB; i++) begin
         word_bytes[i] = ext_w[8*i +: 8];
      end
   end

   assign accept    = Tx_Start && !busy_q && (byte_state == IDLE);
   assign last_byte = (idx_q == IW'(NB - 1));

   always_comb begin
      dato_d     = dato_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      byte_start = 1'b0;
      byte_data  = word_bytes[idx_q];
      if (accept) begin
         dato_d     = Dato;
         idx_d      = '0;
         busy_d     = 1'b1;
         byte_start = 1'b1;
         byte_data  = Dato[7:0];
      end else if (busy_q && byte_done) begin
         if (last_byte) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end else begin
            idx_d      = idx_q + 1'b1;
            byte_start = 1'b1;
            byte_data  = word_bytes[idx_d];
         end
      end
   end

   always_ff @(posedge Clk_G or posedge Rst_G) begin
      if (Rst_G) begin
         dato_q <= '0;
         idx_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         dato_q <= dato_d;
         idx_q  <= idx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
      .Clk_G        (Clk_G),
      .Rst_G        (Rst_G),
      .byte_start_i (byte_start),
      .byte_data_i  (byte_data),
      .tx_o         (Tx),
      .byte_busy_o  (byte_busy),
      .byte_done_o  (byte_done),
      .state_o      (byte_state)
   );

   assign Tx_Busy = busy_q | byte_busy;
   assign Tx_Done = done_q;

endmodule

// File: tb/tb_prueba_tx.sv
// Bench for prueba_tx: cycle-level line model, UART receive scoreboard and
// directed plus randomized word traffic.
module tb_prueba_tx;

   localparam int CB       = 13;
   localparam int W        = 2 * CB;
   localparam int CPB      = 4;
   localparam int NB       = (W + 7) / 8;
   localparam int WORD_CYC = 10 * NB * CPB;

   logic                Clk_G, Rst_G, Tx_Start;
   logic signed [W-1:0] Dato;
   logic                Tx, Tx_Busy, Tx_Done;

   int n_vec = 0;
   int n_err = 0;

   logic       line_q[$];      // expected Tx level for each remaining cycle of the word
   logic       done_flag = 1'b0;
   logic [7:0] exp_q[$];       // bytes expected from the receiver
   logic [7:0] rx_bytes[$];    // bytes decoded off the line
   bit         rx_on = 1'b0;
   int         rx_t = 0;
   logic [7:0] rx_sh = '0;

   prueba_tx #(.cant_bits(CB), .CLKS_PER_BIT(CPB)) dut (
      .Clk_G    (Clk_G),
      .Rst_G    (Rst_G),
      .Tx_Start (Tx_Start),
      .Dato     (Dato),
      .Tx       (Tx),
      .Tx_Busy  (Tx_Busy),
      .Tx_Done  (Tx_Done)
   );

   // ---------------- clock / reset ----------------
   initial Clk_G = 1'b0;
   always #5 Clk_G = ~Clk_G;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // A word is NB sign-extended bytes, each 0 + 8 data bits LSB first + 1, CPB cycles per bit
   function automatic void load_word(input logic signed [W-1:0] d);
      longint     v;
      logic [7:0] b;
      v = longint'(d);
      for (int i = 0; i < NB; i++) begin
         b = 8'((v >> (8 * i)) & 64'hff);
         exp_q.push_back(b);
         for (int c = 0; c < CPB; c++) line_q.push_back(1'b0);
         for (int k = 0; k < 8; k++)
            for (int c = 0; c < CPB; c++) line_q.push_back(b[k]);
         for (int c = 0; c < CPB; c++) line_q.push_back(1'b1);
      end
   endfunction

   // ---------------- per-cycle compare against the line model ----------------
   always @(negedge Clk_G) begin
      logic e_tx, e_busy, e_done;
      bit   cur_busy;
      cur_busy = 1'b0;
      if (Rst_G) begin
         line_q.delete();
         exp_q.delete();
         done_flag = 1'b0;
         e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         cur_busy = (line_q.size() > 0);
         e_tx     = cur_busy ? line_q[0] : 1'b1;
         e_busy   = cur_busy;
         e_done   = done_flag;
      end
      check("tx_line", 32'(Tx), 32'(e_tx));
      check("tx_busy", 32'(Tx_Busy), 32'(e_busy));
      check("tx_done", 32'(Tx_Done), 32'(e_done));
      if (!Rst_G) begin
         if (cur_busy) begin
            void'(line_q.pop_front());
            done_flag = (line_q.size() == 0);
         end else begin
            done_flag = 1'b0;
         end
         if (!cur_busy && Tx_Start) load_word(Dato);
      end
   end

   // ---------------- UART receive scoreboard ----------------
   always @(negedge Clk_G) begin
      int b;
      if (Rst_G) begin
         rx_on = 1'b0;
      end else if (!rx_on) begin
         if (Tx === 1'b0) begin
            rx_on = 1'b1;
            rx_t  = 0;
         end
      end else begin
         rx_t++;
      end
      if (rx_on && !Rst_G && (rx_t % CPB) == CPB / 2) begin
         b = rx_t / CPB;
         if (b == 0) begin
            check("rx_start_bit", 32'(Tx), 32'd0);
         end else if (b <= 8) begin
            rx_sh[b-1] = Tx;
         end else begin
            check("rx_stop_bit", 32'(Tx), 32'd1);
            rx_bytes.push_back(rx_sh);
            check("rx_byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
            rx_on = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge Clk_G);
      #1;
   endtask

   // Called in the first cycle after the accepting edge; n = cycles until Tx_Done
   task automatic wait_word(output int n, output int busy_n);
      n = 0;
      busy_n = 0;
      @(negedge Clk_G);
      while (!Tx_Done && n < WORD_CYC + 40) begin
         busy_n += int'(Tx_Busy);
         @(negedge Clk_G);
         n++;
      end
   endtask

   task automatic check_bytes(input string name, input int cnt, input logic [63:0] exp);
      logic [7:0] e;
      check({name, "_count"}, 32'(rx_bytes.size()), 32'(cnt));
      for (int i = 0; i < cnt; i++) begin
         e = exp[8*i +: 8];
         if (i < rx_bytes.size()) check(name, 32'(rx_bytes[i]), 32'(e));
      end
   endtask

   task automatic pulse_start(input logic signed [W-1:0] d);
      Dato = d;
      Tx_Start = 1'b1;
      tick();
      Tx_Start = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n, busy_n, dn, lows;
      Rst_G = 1'b1;
      Tx_Start = 1'b0;
      Dato = '0;
      repeat (3) tick();
      Rst_G = 1'b0;
      tick();

      // Word 7 -> 07 00 00 00, Done 160 cycles after the first start bit
      rx_bytes.delete();
      pulse_start(W'(7));
      check("t1_first_cycle_low", 32'(Tx), 32'd0);
      wait_word(n, busy_n);
      check("t1_done_latency", 32'(n), 32'd160);
      check_bytes("t1_bytes", 4, 64'h0000_0000_0000_0007);
      tick();

      // Word -7 -> F9 FF FF FF, busy through the whole word
      rx_bytes.delete();
      pulse_start(-W'(7));
      wait_word(n, busy_n);
      check("t2_done_latency", 32'(n), 32'd160);
      check("t2_busy_cycles", 32'(busy_n), 32'd160);
      check_bytes("t2_bytes", 4, 64'h0000_0000_FFFF_FFF9);
      repeat (3) tick();

      // Start while busy is ignored and Dato changes do not leak in
      rx_bytes.delete();
      pulse_start(W'(26'h0012345));
      repeat (49) tick();
      Dato = W'(5);
      Tx_Start = 1'b1;
      tick();
      Tx_Start = 1'b0;
      dn = 0;
      repeat (250) begin
         @(negedge Clk_G);
         dn += int'(Tx_Done);
      end
      check("t3_done_count", 32'(dn), 32'd1);
      check_bytes("t3_bytes", 4, 64'h0000_0000_0001_2345);
      tick();

      // Tx_Start held through Done: second word follows right after Done
      rx_bytes.delete();
      Dato = W'(26'h1ABCDEF);
      Tx_Start = 1'b1;
      tick();
      Dato = W'(26'h2000001);
      wait_word(n, busy_n);
      check("t4_first_latency", 32'(n), 32'd160);
      check("t4_done_line_idle", 32'(Tx), 32'd1);
      @(posedge Clk_G);
      #1;
      Tx_Start = 1'b0;
      check("t4_second_start_low", 32'(Tx), 32'd0);
      check("t4_second_busy", 32'(Tx_Busy), 32'd1);
      wait_word(n, busy_n);
      check("t4_second_latency", 32'(n), 32'd160);
      check_bytes("t4_bytes", 8, 64'hFE00_0001_01AB_CDEF);
      tick();

      // Reset in the middle of byte 2
      rx_bytes.delete();
      pulse_start(W'($urandom()));
      repeat (95) tick();
      Rst_G = 1'b1;
      #1;
      check("t5_rst_tx", 32'(Tx), 32'd1);
      check("t5_rst_busy", 32'(Tx_Busy), 32'd0);
      check("t5_rst_done", 32'(Tx_Done), 32'd0);
      repeat (3) tick();
      Rst_G = 1'b0;
      dn = 0;
      lows = 0;
      repeat (200) begin
         @(negedge Clk_G);
         dn += int'(Tx_Done);
         lows += int'(!Tx);
      end
      check("t5_no_done", 32'(dn), 32'd0);
      check("t5_line_idle", 32'(lows), 32'd0);
      check("t5_bytes_before_reset", 32'(rx_bytes.size()), 32'd2);
      tick();

      // Random sparse requests, including some landing on Done or while busy
      for (int i = 0; i < 3000; i++) begin
         Dato = W'($urandom());
         Tx_Start = ($urandom_range(0, 15) == 0);
         tick();
      end
      // Held request with random data: continuous back-to-back words
      Tx_Start = 1'b1;
      for (int i = 0; i < 700; i++) begin
         Dato = W'($urandom());
         tick();
      end
      Tx_Start = 1'b0;
      repeat (WORD_CYC + 20) tick();
      check("end_all_bytes_received", 32'(exp_q.size()), 32'd0);
      check("end_line_idle", 32'(Tx), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
